// File: rtl/prog_load_dump_ctrl_if.sv
// rtl/prog_load_dump_ctrl_if.sv - bus bundle between the load/dump controller and its surroundings
interface prog_load_dump_ctrl_if #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 12,
  parameter int RF_AW  = 4
) ();
  // image stream in
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;
  logic              s_last;
  // byte memory write and dump read ports
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [ADDR_W-1:0] mem_raddr;
  logic [7:0]        mem_rdata;
  // register file read port
  logic [RF_AW-1:0]  rf_raddr;
  logic [WORD_W-1:0] rf_rdata;
  // core control, dump stream out and status
  logic              cpu_reset;
  logic              m_valid;
  logic              m_ready;
  logic [WORD_W-1:0] m_data;
  logic              m_kind;
  logic              m_last;
  logic              overflow;
  logic              done;

  modport master (
    input  s_valid, s_data, s_last, mem_rdata, rf_rdata, m_ready,
    output s_ready, mem_we, mem_addr, mem_wdata, mem_raddr, rf_raddr,
           cpu_reset, m_valid, m_data, m_kind, m_last, overflow, done
  );

  modport slave (
    output s_valid, s_data, s_last, mem_rdata, rf_rdata, m_ready,
    input  s_ready, mem_we, mem_addr, mem_wdata, mem_raddr, rf_raddr,
           cpu_reset, m_valid, m_data, m_kind, m_last, overflow, done
  );
endinterface

// File: rtl/prog_load_dump_ctrl.sv
// rtl/prog_load_dump_ctrl.sv - program image loader, run-budget gate and register/memory dumper
module prog_load_dump_ctrl #(
  parameter int WORD_W     = 32,
  parameter int MEM_DEPTH  = 4096,
  parameter int ADDR_W     = 12,
  parameter int REG_COUNT  = 16,
  parameter int RUN_CYCLES = 100
) (
  input  logic                   clk,
  input  logic                   reset,
  prog_load_dump_ctrl_if.master  bus
);

  localparam int BYTES = WORD_W / 8;
  localparam int REM_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int CNT_W = ADDR_W + 1;
  localparam int RUN_W = $clog2(RUN_CYCLES + 1);
  localparam int RF_AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] MEM_LAST = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [RF_AW-1:0]  REG_LAST = RF_AW'(REG_COUNT - 1);
  localparam logic [REM_W-1:0]  REM_FULL = REM_W'(BYTES - 1);
  localparam logic [RUN_W-1:0]  RUN_LOAD = RUN_W'(RUN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_RUN,
    S_DUMP_REG,
    S_DUMP_MEM,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [WORD_W-1:0] r_word;      // bytes of the current word not yet emitted, LSB first
  logic [REM_W-1:0]  r_rem;       // bytes still to emit after the one on the bus now
  logic              r_busy;
  logic              r_last_acc;  // the s_last word has been accepted
  logic [CNT_W-1:0]  r_wr_cnt;    // next byte address, saturates at MEM_DEPTH
  logic [RUN_W-1:0]  r_run_cnt;
  logic [RF_AW-1:0]  r_rf_idx;
  logic [ADDR_W-1:0] r_mem_idx;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic              r_cpu_reset;
  logic              r_m_valid;
  logic              r_m_kind;
  logic              r_m_last;
  logic              r_overflow;
  logic              r_done;

  logic              w_s_ready;
  logic              w_accept;
  logic              w_emit;
  logic [7:0]        w_byte;
  logic              w_in_range;
  logic              w_m_fire;

  // Serializer can take a new word when empty or on its final byte cycle
  assign w_s_ready  = (r_state == S_LOAD) && !r_last_acc && (!r_busy || (r_rem == '0));
  assign w_accept   = bus.s_valid && w_s_ready;
  assign w_in_range = (r_wr_cnt < DEPTH_C);
  assign w_m_fire   = r_m_valid && bus.m_ready;

  // Pick the byte to emit this edge: byte 0 of a fresh word or the next buffered byte
  always_comb begin
    w_emit = 1'b0;
    w_byte = 8'h00;
    if (w_accept) begin
      w_emit = 1'b1;
      w_byte = bus.s_data[7:0];
    end else if (r_busy && (r_rem != '0)) begin
      w_emit = 1'b1;
      w_byte = r_word[7:0];
    end
  end

  // Main controller: load serializer, run counter, dump sequencer, all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_LOAD;
      r_word      <= '0;
      r_rem       <= '0;
      r_busy      <= 1'b0;
      r_last_acc  <= 1'b0;
      r_wr_cnt    <= '0;
      r_run_cnt   <= '0;
      r_rf_idx    <= '0;
      r_mem_idx   <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 8'h00;
      r_cpu_reset <= 1'b1;
      r_m_valid   <= 1'b0;
      r_m_kind    <= 1'b0;
      r_m_last    <= 1'b0;
      r_overflow  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_accept) begin
            r_word     <= bus.s_data >> 8;
            r_rem      <= REM_FULL;
            r_busy     <= 1'b1;
            r_last_acc <= bus.s_last;
          end else if (r_busy && (r_rem != '0)) begin
            r_word <= r_word >> 8;
            r_rem  <= r_rem - 1'b1;
          end else if (r_busy) begin
            r_busy <= 1'b0;
            if (r_last_acc) begin
              r_state     <= S_RUN;
              r_cpu_reset <= 1'b0;
              r_run_cnt   <= RUN_LOAD;
            end
          end
          // Out-of-range bytes are dropped but still consume their cycle
          if (w_emit) begin
            if (w_in_range) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_wr_cnt[ADDR_W-1:0];
              r_mem_wdata <= w_byte;
              r_wr_cnt    <= r_wr_cnt + 1'b1;
            end else begin
              r_mem_we   <= 1'b0;
              r_overflow <= 1'b1;
            end
          end else begin
            r_mem_we <= 1'b0;
          end
        end

        S_RUN: begin
          if (r_run_cnt == '0) begin
            r_state     <= S_DUMP_REG;
            r_cpu_reset <= 1'b1;
            r_m_valid   <= 1'b1;
            r_rf_idx    <= '0;
            r_m_kind    <= 1'b0;
            r_m_last    <= 1'b0;
          end else begin
            r_run_cnt <= r_run_cnt - 1'b1;
          end
        end

        S_DUMP_REG: begin
          if (w_m_fire) begin
            if (r_rf_idx == REG_LAST) begin
              r_state   <= S_DUMP_MEM;
              r_mem_idx <= '0;
              r_m_kind  <= 1'b1;
              r_m_last  <= (MEM_DEPTH == 1);
            end else begin
              r_rf_idx <= r_rf_idx + 1'b1;
            end
          end
        end

        S_DUMP_MEM: begin
          if (w_m_fire) begin
            if (r_mem_idx == MEM_LAST) begin
              r_state   <= S_DONE;
              r_m_valid <= 1'b0;
              r_m_last  <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_mem_idx <= r_mem_idx + 1'b1;
              r_m_last  <= ((r_mem_idx + 1'b1) == MEM_LAST);
            end
          end
        end

        S_DONE: begin
          r_done <= 1'b1;
        end

        default: begin
          r_state <= S_LOAD;
        end
      endcase
    end
  end

  assign bus.s_ready   = w_s_ready;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_raddr = r_mem_idx;
  assign bus.rf_raddr  = r_rf_idx;
  assign bus.cpu_reset = r_cpu_reset;
  assign bus.m_valid   = r_m_valid;
  assign bus.m_kind    = r_m_kind;
  assign bus.m_last    = r_m_last;
  assign bus.overflow  = r_overflow;
  assign bus.done      = r_done;
  // Reads are combinational, so the payload follows the current beat address directly
  assign bus.m_data    = (r_state == S_DUMP_REG) ? bus.rf_rdata :
                         (r_state == S_DUMP_MEM) ? WORD_W'(bus.mem_rdata) : '0;

endmodule

// File: tb/tb_prog_load_dump_ctrl.sv
// tb/tb_prog_load_dump_ctrl.sv - self-checking bench for prog_load_dump_ctrl
module tb_prog_load_dump_ctrl;

  localparam int WORD_W     = 32;
  localparam int MEM_DEPTH  = 8;
  localparam int ADDR_W     = 4;
  localparam int REG_COUNT  = 4;
  localparam int RUN_CYCLES = 5;
  localparam int NBEATS     = REG_COUNT + MEM_DEPTH;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  prog_load_dump_ctrl_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W), .RF_AW(2)) bus ();

  prog_load_dump_ctrl #(
    .WORD_W(WORD_W), .MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W),
    .REG_COUNT(REG_COUNT), .RUN_CYCLES(RUN_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // bench-side memory and register file
  logic [7:0]  mem  [0:15];
  logic [7:0]  fill [0:15];
  logic [31:0] regs [0:3];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= fill[i];
    end else if (bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = mem[bus.mem_raddr];
  assign bus.rf_rdata  = regs[bus.rf_raddr];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          c, t_acc, t_last, n_acc, beat;
  bit          last_acc, exp_ovf;
  logic [31:0] cur_word;
  logic [7:0]  exp_mem [0:15];
  int          d_v, a_v;
  bit          bytecyc_v, run_v, dumping_v, exp_we_v;
  logic [7:0]  exp_b;
  logic [31:0] exp_d;

  // observation logs for literal checks
  int          wr_addr_q[$];
  logic [7:0]  wr_data_q[$];
  logic [31:0] beat_q[$];
  int          last_pos_q[$];
  int          run_low;

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    beat_q.delete();
    last_pos_q.delete();
    run_low = 0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      c = 0; t_acc = -100; t_last = -100; n_acc = 0; beat = 0;
      last_acc = 0; exp_ovf = 0; cur_word = '0;
      for (int i = 0; i < 16; i++) exp_mem[i] = fill[i];
    end else begin
      d_v       = c - t_acc;
      bytecyc_v = (d_v >= 1) && (d_v <= WORD_W / 8);
      a_v       = (WORD_W / 8) * (n_acc - 1) + d_v - 1;
      exp_we_v  = bytecyc_v && (a_v < MEM_DEPTH);
      if (bytecyc_v && a_v >= MEM_DEPTH) exp_ovf = 1;
      exp_b = 8'(cur_word >> (8 * (d_v - 1)));
      if (exp_we_v) exp_mem[a_v] = exp_b;
      run_v     = last_acc && (c >= t_last + 5) && (c <= t_last + 4 + RUN_CYCLES);
      dumping_v = last_acc && (c >= t_last + 5 + RUN_CYCLES) && (beat < NBEATS);

      chk("s_ready", 32'(bus.s_ready), 32'(!last_acc && (c >= t_acc + 4)));
      chk("mem_we", 32'(bus.mem_we), 32'(exp_we_v));
      if (exp_we_v) begin
        chk("mem_addr", 32'(bus.mem_addr), 32'(a_v));
        chk("mem_wdata", 32'(bus.mem_wdata), 32'(exp_b));
      end
      chk("overflow", 32'(bus.overflow), 32'(exp_ovf));
      chk("cpu_reset", 32'(bus.cpu_reset), 32'(!run_v));
      chk("m_valid", 32'(bus.m_valid), 32'(dumping_v));
      chk("done", 32'(bus.done), 32'(last_acc && beat == NBEATS));
      if (dumping_v) begin
        if (beat < REG_COUNT) begin
          exp_d = regs[beat];
          chk("m_kind", 32'(bus.m_kind), 32'd0);
          chk("rf_raddr", 32'(bus.rf_raddr), 32'(beat));
        end else begin
          exp_d = {24'h0, exp_mem[beat - REG_COUNT]};
          chk("m_kind", 32'(bus.m_kind), 32'd1);
          chk("mem_raddr", 32'(bus.mem_raddr), 32'(beat - REG_COUNT));
        end
        chk("m_data", bus.m_data, exp_d);
        chk("m_last", 32'(bus.m_last), 32'(beat == NBEATS - 1));
      end

      if (bus.mem_we) begin
        wr_addr_q.push_back(int'(bus.mem_addr));
        wr_data_q.push_back(bus.mem_wdata);
      end
      if (!bus.cpu_reset) run_low++;
      if (bus.m_valid && bus.m_ready) begin
        if (bus.m_last) last_pos_q.push_back(beat_q.size());
        beat_q.push_back(bus.m_data);
      end

      // edge at the end of this cycle
      if (bus.s_valid && !last_acc && (c >= t_acc + 4)) begin
        t_acc    = c;
        n_acc++;
        cur_word = bus.s_data;
        if (bus.s_last) begin
          last_acc = 1;
          t_last   = c;
        end
      end
      if (dumping_v && bus.m_ready) beat++;
      c++;
    end
  end

  // ---------------- stimulus ----------------
  int          m_mode = 2;
  int          m_k = 0;
  logic [3:0]  pat = 4'b1001;
  logic [31:0] w_q[$];
  int          g_q[$];
  logic [7:0]  lit[8];

  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (m_mode)
        0:       bus.m_ready = pat[m_k % 4];
        1:       bus.m_ready = 1'($urandom % 2);
        default: bus.m_ready = 1'b1;
      endcase
      m_k++;
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_s_ready"},   32'(bus.s_ready), 32'd1);
    chk({tag, "_mem_we"},    32'(bus.mem_we), 32'd0);
    chk({tag, "_mem_addr"},  32'(bus.mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    chk({tag, "_mem_raddr"}, 32'(bus.mem_raddr), 32'd0);
    chk({tag, "_rf_raddr"},  32'(bus.rf_raddr), 32'd0);
    chk({tag, "_cpu_reset"}, 32'(bus.cpu_reset), 32'd1);
    chk({tag, "_m_valid"},   32'(bus.m_valid), 32'd0);
    chk({tag, "_m_data"},    bus.m_data, 32'd0);
    chk({tag, "_m_kind"},    32'(bus.m_kind), 32'd0);
    chk({tag, "_m_last"},    32'(bus.m_last), 32'd0);
    chk({tag, "_overflow"},  32'(bus.overflow), 32'd0);
    chk({tag, "_done"},      32'(bus.done), 32'd0);
  endtask

  task automatic randomize_env();
    for (int i = 0; i < 16; i++) fill[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) regs[i] = $urandom;
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals(tag);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic feed();
    int start, guard;
    for (int i = 0; i < w_q.size(); i++) begin
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      repeat (g_q[i]) begin
        @(posedge clk);
        #1;
      end
      bus.s_valid = 1'b1;
      bus.s_data  = w_q[i];
      bus.s_last  = (i == w_q.size() - 1);
      start = n_acc;
      guard = 0;
      while (n_acc == start && guard < 50) begin
        @(posedge clk);
        #1;
        guard++;
      end
      checks++;
      if (n_acc == start) begin
        errors++;
        $display("FAIL accept_timeout: word %0d not accepted within %0d cycles", i, guard);
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_done();
    int guard = 0;
    while (!(last_acc && beat == NBEATS) && guard < 400) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checks++;
    if (!(last_acc && beat == NBEATS)) begin
      errors++;
      $display("FAIL done_timeout: model beat %0d of %0d after %0d cycles", beat, NBEATS, guard);
    end
  endtask

  task automatic random_words(input int nw, input int maxgap);
    w_q.delete();
    g_q.delete();
    for (int i = 0; i < nw; i++) begin
      w_q.push_back($urandom);
      g_q.push_back($urandom_range(0, maxgap));
    end
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    randomize_env();

    // image load, run budget and dump with 1,0,0,1 backpressure
    regs[0] = 32'd1; regs[1] = 32'd2; regs[2] = 32'd3; regs[3] = 32'd4;
    do_reset("rst0");
    m_k = 0; m_mode = 0;
    w_q = '{32'h11223344, 32'hAABBCCDD};
    g_q = '{0, 0};
    feed();
    wait_done();
    lit = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
    chk("load_wr_count", 32'(wr_addr_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < wr_addr_q.size(); i++) begin
      chk("load_wr_addr", 32'(wr_addr_q[i]), 32'(i));
      chk("load_wr_data", 32'(wr_data_q[i]), 32'(lit[i]));
    end
    chk("run_low_cycles", 32'(run_low), 32'd5);
    chk("dump_beat_count", 32'(beat_q.size()), 32'd12);
    for (int i = 0; i < 12 && i < beat_q.size(); i++)
      chk("dump_beat", beat_q[i], (i < 4) ? 32'(i + 1) : {24'h0, lit[i - 4]});
    chk("m_last_count", 32'(last_pos_q.size()), 32'd1);
    if (last_pos_q.size() > 0) chk("m_last_pos", 32'(last_pos_q[0]), 32'd11);
    chk("load_overflow", 32'(bus.overflow), 32'd0);
    chk("load_done", 32'(bus.done), 32'd1);

    // overflow: third word lands past the end of memory
    randomize_env();
    do_reset("rst1");
    m_mode = 2;
    random_words(3, 0);
    feed();
    wait_done();
    chk("ovf_flag", 32'(bus.overflow), 32'd1);
    chk("ovf_wr_count", 32'(wr_addr_q.size()), 32'd8);
    chk("ovf_beat_count", 32'(beat_q.size()), 32'd12);

    // source stall of three cycles between words
    randomize_env();
    do_reset("rst2");
    m_mode = 1;
    random_words(2, 0);
    g_q[1] = 3;
    feed();
    wait_done();
    chk("stall_wr_count", 32'(wr_addr_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < wr_addr_q.size(); i++)
      chk("stall_wr_addr", 32'(wr_addr_q[i]), 32'(i));

    // reset during memory dump beat 3, then a fresh load
    randomize_env();
    do_reset("rst3");
    m_mode = 1;
    random_words(2, 2);
    feed();
    begin
      int guard = 0;
      while (!(last_acc && beat == REG_COUNT + 3) && guard < 400) begin
        @(posedge clk);
        #2;
        guard++;
      end
      checks++;
      if (!(last_acc && beat == REG_COUNT + 3)) begin
        errors++;
        $display("FAIL middump_timeout: model beat %0d", beat);
      end
    end
    reset = 1'b1;
    #1;
    check_reset_vals("middump");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_logs();
    random_words(1, 1);
    feed();
    wait_done();
    chk("fresh_wr_count", 32'(wr_addr_q.size()), 32'd4);
    if (wr_addr_q.size() > 0) chk("fresh_first_addr", 32'(wr_addr_q[0]), 32'd0);

    // randomized episodes
    for (int e = 0; e < 8; e++) begin
      randomize_env();
      do_reset("rstr");
      m_mode = int'($urandom_range(0, 2));
      random_words(int'($urandom_range(1, 3)), 3);
      feed();
      wait_done();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/prog_load_dump_ctrl.md
# prog_load_dump_ctrl

Synthesizable controller for loading and dumping the pipeline processor's program image. It streams a program image into the processor's byte-wide data/instruction memory while holding the core in reset, then releases the core for a fixed cycle budget. After the budget expires, it re-asserts core reset and streams out the register file followed by the full memory contents. Width, memory depth, register count and run budget are parameters, so the same block serves every core variant and works on silicon as well as in simulation.

## Interface
- WORD_W, 32, image/register word width in bits; multiple of 8
- MEM_DEPTH, 4096, memory size in bytes
- ADDR_W, 12, memory address width; 2^ADDR_W >= MEM_DEPTH
- REG_COUNT, 16, registers dumped (indices 0..REG_COUNT-1)
- RUN_CYCLES, 100, cycles the core runs with reset released; >= 1

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; one clock, async active-high reset (fixed)
- s_valid  in  1  image word valid
- s_ready  out  1  image word accepted when s_valid && s_ready at the clock edge
- s_data  in  WORD_W  image word, little-endian byte order
- s_last  in  1  final image word
- mem_we  out  1  byte write strobe
- mem_addr  out  ADDR_W  byte write address
- mem_wdata  out  8  byte write data
- mem_raddr  out  ADDR_W  dump read address; memory read is combinational
- mem_rdata  in  8  byte at mem_raddr, same cycle
- rf_raddr  out  $clog2(REG_COUNT)  register read address; read is combinational
- rf_rdata  in  WORD_W  register at rf_raddr, same cycle
- cpu_reset  out  1  core reset; high except in RUN
- m_valid  out  1  dump beat valid
- m_ready  in  1  dump sink ready
- m_data  out  WORD_W  dump payload; memory bytes are zero-extended
- m_kind  out  1  0 = register beat, 1 = memory beat
- m_last  out  1  final dump beat (memory byte MEM_DEPTH-1)
- overflow  out  1  sticky: image exceeded MEM_DEPTH
- done  out  1  dump complete

## Operation
- FSM states: LOAD, RUN, DUMP_REG, DUMP_MEM, DONE. Reset enters LOAD.
- LOAD: an accepted word is latched into the byte serializer. Over the next BYTES = WORD_W/8 cycles, bytes 0..BYTES-1 are written, one per cycle, at wr_addr, wr_addr+1, and so on. mem_we is high on each of those cycles. s_ready is high when the serializer is empty or on its final byte cycle, so back-to-back words sustain one word per BYTES cycles.
- Address rule: wr_addr starts at 0 and does not wrap. If a byte address would be >= MEM_DEPTH, that write is suppressed (mem_we low) and overflow is set. The word is still accepted, so the stream never stalls.
- Once the final byte of the s_last word has been written or suppressed, the FSM moves to RUN. An s_last word with s_valid never asserted never reaches RUN.
- RUN: cpu_reset is low for exactly RUN_CYCLES cycles, tracked by a down-counter. The FSM then moves to DUMP_REG.
- DUMP_REG: beat i (0..REG_COUNT-1) presents rf_raddr=i, m_data=rf_rdata, m_kind=0. The beat index advances only on m_valid && m_ready. After the last register beat transfers, the FSM moves to DUMP_MEM.
- DUMP_MEM: beat j (0..MEM_DEPTH-1) presents mem_raddr=j, m_data={0, mem_rdata}, m_kind=1. m_last is high only at j=MEM_DEPTH-1. After that beat transfers, the FSM moves to DONE.
- Handshake: once m_valid is high, it stays high and the beat index stays stable until the beat transfers.
- DONE: done=1, cpu_reset=1, m_valid=0. DONE is held until reset.
- Memory bytes not covered by the image are not cleared by this block.

## Timing
- Reset values: state=LOAD, s_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, mem_raddr=0, rf_raddr=0, cpu_reset=1, m_valid=0, m_data=0, m_kind=0, m_last=0, overflow=0, done=0.
- If a word is accepted at edge k, its bytes are written in cycles k+1..k+BYTES.
- The first RUN cycle is the cycle after the final byte write. cpu_reset falls at that edge and rises again RUN_CYCLES edges later.
- m_valid rises at the same edge that enters DUMP_REG. With m_ready held high, the dump takes REG_COUNT+MEM_DEPTH cycles. done rises on the edge after the m_last transfer.
- Reset asserted mid-operation, in any state: outputs go to their reset values immediately. Any partial word or beat is discarded, and counters are cleared.
- Simultaneous events: s_valid with s_ready low is ignored, and the source must hold s_valid and s_data. Deasserting m_ready while m_valid is high stalls the dump with no data change.

## Test plan
- Image load: WORD_W=32, words 0x11223344 then 0xAABBCCDD (last) -> bytes 44,33,22,11,DD,CC,BB,AA written to addresses 0..7; overflow=0; RUN entered the cycle after address 7 is written.
- Run budget: RUN_CYCLES=5 -> cpu_reset low for exactly 5 consecutive cycles, then high.
- Dump with backpressure: REG_COUNT=4, registers 1,2,3,4, MEM_DEPTH=8; m_ready toggling 1,0,0,1 -> 12 beats in order, values stable during stalls, m_last only on the memory beat at address 7, done=1 afterward.
- Overflow: MEM_DEPTH=8, three words, last on the third -> third word's bytes suppressed (mem_we=0), overflow=1, FSM proceeds to RUN.
- Source stall: s_valid gap of 3 cycles between words -> no writes during the gap; addresses contiguous.
- Mid-dump reset: assert reset during DUMP_MEM beat 3 -> all outputs at reset values within the same cycle; a fresh load after release starts at mem_addr=0.
